crop_video_window: RTL

- Streaming crop engine. Consumes the crop_x/crop_y/crop_width/crop_height configuration driven on the crop_video_config bus and applies it to an AXI4-Stream-style video input, one pixel per beat.
- Forwards only pixels inside the crop rectangle and regenerates start-of-frame (SOF) and end-of-line (EOL) markers for the cropped stream.
- Sits directly downstream of the config agent and upstream of the video sink.

---
 rtl/crop_video_window.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/crop_video_window.sv
// Purpose    : streaming crop of a one-pixel-per-beat video stream to a rectangle, with SOF/EOL regenerated.
// Latency    : 1 cycle from input accept to m_tvalid (single output register stage).
// Backpressure: s_tready = !m_tvalid || m_tready; the m_* outputs hold while stalled; 1 beat/cycle when m_tready=1.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   crop_x/y/width/height    crop rectangle, sampled on each accepted SOF beat
//   s_tdata/tvalid/tready    input pixel stream; s_tuser = SOF, s_tlast = EOL
//   s_tuser/tlast
//   m_tdata/tvalid/tready    cropped pixel stream; m_tuser = SOF, m_tlast = EOL
//   m_tuser/tlast
//   frame_empty              one-cycle pulse at a SOF when the frame just ended kept no pixels
module crop_video_window #(
    parameter int DATA_W = 24,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIM_W-1:0]  crop_x,
    input  logic [DIM_W-1:0]  crop_y,
    input  logic [DIM_W-1:0]  crop_width,
    input  logic [DIM_W-1:0]  crop_height,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              frame_empty
);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam logic [DIM_W-1:0] DIM_MAX = '1;
    localparam logic [DIM_W-1:0] ONE_D   = 1;
    localparam logic [DIM_W:0]   ONE_E   = 1;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  x_q, y_q;
    logic [DIM_W-1:0]  sh_x, sh_y, sh_w, sh_h;
    logic              pend_q;      // first kept beat of the frame still owes m_tuser
    logic              any_q;       // current frame has kept at least one beat

    logic              accept, sof, process, keep, kept, at_x_end;
    logic [DIM_W-1:0]  eff_x, eff_y, eff_w, eff_h;
    logic [DIM_W-1:0]  cur_x, cur_y, x_inc, y_inc;
    logic [DIM_W:0]    x_end, y_end;

    assign s_tready = !m_tvalid || m_tready;
    assign accept   = s_tvalid && s_tready;
    assign sof      = accept && s_tuser;
    // Beats before the first SOF are swallowed; the SOF beat itself is processed.
    assign process  = accept && ((state_q == ACTIVE) || s_tuser);

    // The SOF beat sees the live config; the rest of the frame sees the copy taken at SOF.
    assign eff_x = s_tuser ? crop_x      : sh_x;
    assign eff_y = s_tuser ? crop_y      : sh_y;
    assign eff_w = s_tuser ? crop_width  : sh_w;
    assign eff_h = s_tuser ? crop_height : sh_h;

    // SOF forces this beat to (0,0), which also resyncs a SOF arriving mid-frame.
    assign cur_x = s_tuser ? '0 : x_q;
    assign cur_y = s_tuser ? '0 : y_q;

    // One extra bit so crop_x+crop_width cannot wrap; zero width/height gives an empty range.
    assign x_end = {1'b0, eff_x} + {1'b0, eff_w};
    assign y_end = {1'b0, eff_y} + {1'b0, eff_h};

    assign keep = ({1'b0, cur_x} >= {1'b0, eff_x}) && ({1'b0, cur_x} < x_end) &&
                  ({1'b0, cur_y} >= {1'b0, eff_y}) && ({1'b0, cur_y} < y_end);
    assign kept     = process && keep;
    assign at_x_end = ({1'b0, cur_x} == (x_end - ONE_E));

    // Counters stick at all-ones instead of wrapping back into the window.
    assign x_inc = (cur_x == DIM_MAX) ? DIM_MAX : cur_x + ONE_D;
    assign y_inc = (cur_y == DIM_MAX) ? DIM_MAX : cur_y + ONE_D;

    always_comb begin
        state_d = state_q;
        if (sof) begin
            state_d = ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            sh_x        <= '0;
            sh_y        <= '0;
            sh_w        <= '0;
            sh_h        <= '0;
            pend_q      <= 1'b0;
            any_q       <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tuser     <= 1'b0;
            m_tlast     <= 1'b0;
            frame_empty <= 1'b0;
        end else begin
            state_q <= state_d;

            if (process) begin
                // EOL wins over SOF for x so a SOF+EOL beat is a one-pixel line.
                if (s_tlast) begin
                    x_q <= '0;
                    y_q <= y_inc;
                end else begin
                    x_q <= x_inc;
                    y_q <= cur_y;
                end
            end

            if (sof) begin
                sh_x <= crop_x;
                sh_y <= crop_y;
                sh_w <= crop_width;
                sh_h <= crop_height;
            end

            // Output register reloads whenever it is free or draining this cycle.
            if (s_tready) begin
                m_tvalid <= kept;
                if (kept) begin
                    m_tdata <= s_tdata;
                    m_tuser <= s_tuser || pend_q;
                    m_tlast <= at_x_end || s_tlast;
                end
            end

            if (sof) begin
                pend_q <= !kept;
            end else if (kept) begin
                pend_q <= 1'b0;
            end

            // No previous frame exists before the first SOF, hence the ACTIVE qualifier.
            frame_empty <= sof && (state_q == ACTIVE) && !any_q;
            if (sof) begin
                any_q <= kept;
            end else if (kept) begin
                any_q <= 1'b1;
            end
        end
    end

endmodule
